// File: rtl/sbox_init_sequencer.sv
// Loads the four bcrypt S-box banks from the pi-constant ROM, one word per FETCH/WRITE pair,
// and shares the SRAM write port with the core's Feistel write-back path.
module sbox_init_sequencer #(
  parameter  int NUM_BOX       = 4,
  parameter  int WORDS_PER_BOX = 256,
  parameter  int ADDR_W        = 8,
  parameter  int DATA_W        = 32,
  localparam int BOX_W         = $clog2(NUM_BOX),
  localparam int CNT_W         = BOX_W + ADDR_W
) (
  input  logic               clk,
  input  logic               int_rst_l,
  input  logic               init_req,
  output logic [CNT_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  input  logic               sram_ready,
  output logic               wr_en,
  output logic [NUM_BOX-1:0] wr_cs,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  input  logic               core_req,
  output logic               core_gnt,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BOX * WORDS_PER_BOX - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pend, w_pend_nxt;
  logic               r_gnt, w_gnt_nxt;
  logic               r_hold, w_hold_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               w_wr, w_start;
  logic [DATA_W-1:0]  w_rd_data;

  always_ff @(posedge clk or negedge int_rst_l) begin
    if (!int_rst_l) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_gnt   <= 1'b0;
      r_hold  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_gnt   <= w_gnt_nxt;
      r_hold  <= w_hold_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // A fill may only start once the core has released the port; a request seen
  // while the core holds it is parked in r_pend and blocks any new grant.
  assign w_start = (r_state == S_IDLE || r_state == S_DONE) && !r_gnt && (init_req || r_pend);

  // Registered ROM: rom_data is live only in the first WRITE cycle, so a stalled
  // write replays the copy captured in r_data.
  assign w_rd_data = r_hold ? r_data : rom_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_gnt_nxt   = 1'b0;
    w_hold_nxt  = r_hold;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else if (init_req && r_gnt) begin
          w_pend_nxt  = 1'b1;
        end
        w_gnt_nxt = core_req && (r_gnt || (!r_pend && !init_req));
      end
      S_FETCH: begin
        w_state_nxt = S_WRITE;
        w_hold_nxt  = 1'b0;
      end
      S_WRITE: begin
        if (sram_ready) begin
          w_hold_nxt = 1'b0;
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_hold_nxt = 1'b1;
          w_data_nxt = w_rd_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr     = (r_state == S_WRITE);
  assign wr_en    = w_wr;
  assign wr_addr  = w_wr ? r_cnt[ADDR_W-1:0] : '0;
  assign wr_data  = w_wr ? w_rd_data : '0;
  assign rom_addr = (r_state == S_FETCH) ? r_cnt : '0;
  assign core_gnt = r_gnt;
  assign busy     = (r_state == S_FETCH) || w_wr;
  assign done     = (r_state == S_DONE);

  for (genvar b = 0; b < NUM_BOX; b++) begin : g_cs
    assign wr_cs[b] = w_wr && (r_cnt[CNT_W-1:ADDR_W] == BOX_W'(b));
  end

endmodule

// File: tb/tb_sbox_init_sequencer.sv
// Scoreboard bench for sbox_init_sequencer: stimulus queues expected writes, a
// negedge monitor checks every presented write against the queue head.
module tb_sbox_init_sequencer;

  logic        clk = 1'b0;
  logic        int_rst_l = 1'b0;
  logic        init_req = 1'b0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic        sram_ready = 1'b1;
  logic        wr_en;
  logic [3:0]  wr_cs;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_req = 1'b0;
  logic        core_gnt;
  logic        busy;
  logic        done;

  sbox_init_sequencer dut (
    .clk(clk), .int_rst_l(int_rst_l), .init_req(init_req),
    .rom_addr(rom_addr), .rom_data(rom_data), .sram_ready(sram_ready),
    .wr_en(wr_en), .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_req(core_req), .core_gnt(core_gnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM model: data = address ^ 0xA5A5A5A5, one cycle after the address.
  always @(posedge clk) rom_data <= {22'h0, rom_addr} ^ 32'hA5A5A5A5;

  typedef struct packed {
    logic [3:0]  cs;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int n_acc = 0, n_stall = 0, n_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill();
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      exp_t e;
      a = i[9:0];
      e.cs   = 4'b0001 << a[9:8];
      e.addr = a[7:0];
      e.data = {22'h0, a} ^ 32'hA5A5A5A5;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 6000; k++) begin
      if (done) break;
      tick();
    end
    if (k == 6000) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: every write cycle is compared to the queue head; accepted writes pop it.
  always @(negedge clk) begin
    if (int_rst_l) begin
      if (busy) begin
        n_busy++;
        chk("gnt_while_busy", {63'd0, core_gnt}, 64'd0);
      end
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("spurious_write", 64'd1, 64'd0);
        end else begin
          chk("write", {20'd0, wr_cs, wr_addr, wr_data}, {20'd0, q[0]});
          if (sram_ready) begin
            void'(q.pop_front());
            n_acc++;
          end else begin
            n_stall++;
          end
        end
      end
    end
  end

  function automatic logic [63:0] outs();
    return {6'd0, rom_addr, wr_en, wr_cs, wr_addr, wr_data, core_gnt, busy, done};
  endfunction

  initial begin
    // 1: reset values, then a full fill with sram_ready high
    #2;
    chk("reset_outputs", outs(), 64'd0);
    tick();
    int_rst_l = 1'b1;
    tick();
    chk("idle_outputs", outs(), 64'd0);
    push_fill();
    n_acc = 0; n_busy = 0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("busy_on_start", {63'd0, busy}, 64'd1);
    wait_done();
    chk("fill1_done", {62'd0, busy, done}, 64'd1);
    chk("fill1_busy_cycles", 64'(n_busy), 64'd2048);
    chk("fill1_writes", 64'(n_acc), 64'd1024);
    chk("fill1_queue_empty", 64'(q.size()), 64'd0);

    // 3: stall three cycles on word 0x105
    push_fill();
    n_acc = 0; n_stall = 0; n_busy = 0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("done_clears", {63'd0, done}, 64'd0);
    for (int k = 0; k < 1000; k++) begin
      if (wr_en && wr_cs == 4'b0010 && wr_addr == 8'h05) break;
      tick();
    end
    sram_ready = 1'b0;
    repeat (3) tick();
    chk("stall_held_addr", {52'd0, wr_en, wr_cs, wr_addr}, {52'd0, 1'b1, 4'b0010, 8'h05});
    sram_ready = 1'b1;
    wait_done();
    chk("stall_cycles", 64'(n_stall), 64'd3);
    chk("fill2_busy_cycles", 64'(n_busy), 64'd2051);
    chk("fill2_writes", 64'(n_acc), 64'd1024);
    chk("fill2_queue_empty", 64'(q.size()), 64'd0);

    // 4: arbitration with a fill request parked behind a core grant
    core_req = 1'b1;
    tick();
    chk("gnt_rise", {63'd0, core_gnt}, 64'd1);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("pend_no_start", {61'd0, core_gnt, busy, done}, {61'd0, 3'b101});
    repeat (3) tick();
    chk("pend_still_idle", {62'd0, core_gnt, busy}, {62'd0, 2'b10});
    push_fill();
    n_acc = 0;
    core_req = 1'b0;
    tick();
    chk("gnt_fall", {62'd0, core_gnt, busy}, 64'd0);
    tick();
    chk("pend_fetch", {51'd0, busy, wr_en, rom_addr, core_gnt}, {51'd0, 1'b1, 1'b0, 10'd0, 1'b0});
    repeat (100) tick();
    core_req = 1'b1;
    wait_done();
    chk("gnt_low_at_done", {63'd0, core_gnt}, 64'd0);
    tick();
    chk("gnt_after_done", {63'd0, core_gnt}, 64'd1);
    chk("fill3_writes", 64'(n_acc), 64'd1024);
    core_req = 1'b0;
    tick();
    chk("gnt_release", {63'd0, core_gnt}, 64'd0);

    // 5: simultaneous init_req and core_req with no grant held
    push_fill();
    init_req = 1'b1;
    core_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("simul_seq_wins", {62'd0, busy, core_gnt}, {62'd0, 2'b10});
    wait_done();
    chk("simul_gnt_low_at_done", {63'd0, core_gnt}, 64'd0);
    tick();
    chk("simul_gnt_after_done", {63'd0, core_gnt}, 64'd1);
    core_req = 1'b0;
    tick();
    chk("simul_queue_empty", 64'(q.size()), 64'd0);

    // 6: asynchronous reset at word 500, then restart from word 0
    push_fill();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (wr_en && wr_cs == 4'b0010 && wr_addr == 8'hF4) break;
      tick();
    end
    chk("words_before_reset", 64'(q.size()), 64'd524);
    int_rst_l = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 64'd0);
    q.delete();
    tick();
    int_rst_l = 1'b1;
    tick();
    push_fill();
    n_acc = 0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    tick();
    chk("restart_first_word", {20'd0, wr_cs, wr_addr, wr_data}, {20'd0, 4'b0001, 8'h00, 32'hA5A5A5A5});
    repeat (50) tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    wait_done();
    chk("fill5_writes", 64'(n_acc), 64'd1024);
    chk("fill5_queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
